// File: rtl/twofish_byte_host_pkg.sv
`default_nettype none
// ---- twofish_host_pkg: shared states and constants for the Twofish byte host ----
// ---- Revision: 1.0 ----
package twofish_host_pkg;

    localparam int   BLOCK_BYTES = 16;
    localparam logic ENC         = 1'b0;
    localparam logic DEC         = 1'b1;

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        CRST      = 3'd1,
        CSTART    = 3'd2,
        WAIT_RISE = 3'd3,
        RUN       = 3'd4,
        CAPTURE   = 3'd5,
        DRAIN     = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/twofish_byte_host_if.sv
`default_nettype none
// ---- twofish_byte_host_if: byte-wide host link (input stream, output stream, operands) ----
// ---- Revision: 1.0 ----
interface twofish_byte_host_if;

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         en_de;
    logic [127:0] key;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    modport master (
        output in_data, in_valid, en_de, key, out_ready,
        input  in_ready, out_data, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, en_de, key, out_ready,
        output in_ready, out_data, out_valid, err
    );

endinterface
`default_nettype wire

// File: rtl/twofish_byte_host_serializer.sv
`default_nettype none
// ---- byte_serializer_128: loads a 128-bit word and emits it MSB byte first over valid/ready ----
// ---- Revision: 1.0 ----
module byte_serializer_128
    import twofish_host_pkg::*;
(
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    input  wire logic         load_i,
    input  wire logic [127:0] data_i,
    input  wire logic         ready_i,
    output logic [7:0]        data_o,
    output logic              valid_o,
    output logic              last_o
);

    logic [127:0] sr_q, sr_d;
    logic [3:0]   ocnt_q, ocnt_d;
    logic         valid_q, valid_d;
    logic         w_fire;

    assign w_fire  = valid_q & ready_i;
    assign last_o  = w_fire && (ocnt_q == 4'(BLOCK_BYTES - 1));
    assign data_o  = sr_q[127:120];
    assign valid_o = valid_q;

    always_comb begin
        sr_d    = sr_q;
        ocnt_d  = ocnt_q;
        valid_d = valid_q;
        if (load_i) begin
            sr_d    = data_i;
            ocnt_d  = '0;
            valid_d = 1'b1;
        end else if (w_fire) begin
            sr_d   = {sr_q[119:0], 8'h00};
            ocnt_d = ocnt_q + 4'd1;
            if (last_o) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q    <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            ocnt_q  <= ocnt_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/twofish_byte_host.sv
`default_nettype none
// ---- twofish_byte_host: collects a 16-byte block, sequences the Twofish core, streams the result ----
// ---- Revision: 1.0 ----
module twofish_byte_host
    import twofish_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RISE_WINDOW    = 4
) (
    input  wire logic         Clk,
    input  wire logic         Reset_n,
    twofish_byte_host_if.slave host,
    output logic [127:0]      core_block,
    output logic [127:0]      core_key,
    output logic              core_en_de,
    output logic              core_reset,
    output logic              core_start,
    input  wire logic [127:0] core_o,
    input  wire logic         core_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [127:0]    block_q, block_d;
    logic [127:0]    key_q, key_d;
    logic            ende_q, ende_d;
    logic            creset_q, creset_d;
    logic            cstart_q, cstart_d;
    logic            err_q, err_d;
    logic            w_load;
    logic            w_last;
    logic            w_tmo;

    assign w_tmo = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    assign host.in_ready = (state_q == COLLECT);
    assign host.err      = err_q;
    assign core_block    = block_q;
    assign core_key      = key_q;
    assign core_en_de    = ende_q;
    assign core_reset    = creset_q;
    assign core_start    = cstart_q;

    // Pulse outputs are registered on the transition into the state that owns them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        block_d  = block_q;
        key_d    = key_q;
        ende_d   = ende_q;
        creset_d = 1'b0;
        cstart_d = 1'b0;
        err_d    = 1'b0;
        w_load   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (host.in_valid) begin
                    block_d = {block_q[119:0], host.in_data};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        key_d    = host.key;
                        ende_d   = host.en_de;
                        creset_d = 1'b1;
                        state_d  = CRST;
                    end
                end
            end
            CRST: begin
                cstart_d = 1'b1;
                state_d  = CSTART;
            end
            CSTART: begin
                tcnt_d  = '0;
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                tcnt_d = tcnt_q + TW'(1);
                if (w_tmo) begin
                    err_d    = 1'b1;
                    creset_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = COLLECT;
                end else if (core_busy) begin
                    state_d = RUN;
                end else if (tcnt_q == TW'(RISE_WINDOW - 1)) begin
                    state_d = CAPTURE;
                end
            end
            RUN: begin
                tcnt_d = tcnt_q + TW'(1);
                if (w_tmo) begin
                    err_d    = 1'b1;
                    creset_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = COLLECT;
                end else if (!core_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                w_load  = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (w_last) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            block_q  <= '0;
            key_q    <= '0;
            ende_q   <= 1'b0;
            creset_q <= 1'b0;
            cstart_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            block_q  <= block_d;
            key_q    <= key_d;
            ende_q   <= ende_d;
            creset_q <= creset_d;
            cstart_q <= cstart_d;
            err_q    <= err_d;
        end
    end

    byte_serializer_128 u_ser (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .load_i  (w_load),
        .data_i  (core_o),
        .ready_i (host.out_ready),
        .data_o  (host.out_data),
        .valid_o (host.out_valid),
        .last_o  (w_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_twofish_byte_host.sv
`default_nettype none
`timescale 1ns/1ps
// ---- tb_twofish_byte_host: directed bench with a behavioural Twofish core (key = 0 answers) ----
// ---- Revision: 1.0 ----
module tb_twofish_byte_host;
    import twofish_host_pkg::*;

    localparam logic [127:0] CT = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    twofish_byte_host_if hif();

    logic [127:0] core_block, core_key;
    logic         core_en_de, core_reset, core_start;
    logic [127:0] core_o = '0;
    logic         core_busy = 1'b0;

    twofish_byte_host #(.TIMEOUT_CYCLES(16), .RISE_WINDOW(4)) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .host       (hif),
        .core_block (core_block),
        .core_key   (core_key),
        .core_en_de (core_en_de),
        .core_reset (core_reset),
        .core_start (core_start),
        .core_o     (core_o),
        .core_busy  (core_busy)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural core: 0 = normal run, 1 = busy stuck high, 2 = finishes without raising busy
    int core_mode = 0;
    int run_left  = 0;

    function automatic logic [127:0] model_cipher(input logic d, input logic [127:0] b, input logic [127:0] k);
        if (k == '0 && d == ENC && b == '0) return CT;
        if (k == '0 && d == DEC && b == CT) return '0;
        return ~b ^ k;
    endfunction

    always @(posedge clk) begin
        if (core_reset) begin
            core_busy <= 1'b0;
            run_left  <= 0;
        end else if (core_start) begin
            if (core_mode == 2) begin
                core_o <= model_cipher(core_en_de, core_block, core_key);
            end else begin
                core_busy <= 1'b1;
                run_left  <= 6;
            end
        end else if (core_busy && core_mode != 1) begin
            if (run_left == 0) begin
                core_busy <= 1'b0;
                core_o    <= model_cipher(core_en_de, core_block, core_key);
            end else begin
                run_left <= run_left - 1;
            end
        end
    end

    int cyc = 0;
    int n_rst, n_start, n_err, n_ov;
    int last_rst_cyc, last_start_cyc, last_err_cyc, first_ov_cyc;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (core_reset) begin n_rst++; last_rst_cyc = cyc; end
        if (core_start) begin n_start++; last_start_cyc = cyc; end
        if (hif.err) begin n_err++; last_err_cyc = cyc; end
        if (hif.out_valid) begin
            if (n_ov == 0) first_ov_cyc = cyc;
            n_ov++;
        end
    end

    task automatic clear_mon();
        n_rst = 0; n_start = 0; n_err = 0; n_ov = 0;
        last_rst_cyc = -1; last_start_cyc = -1; last_err_cyc = -1; first_ov_cyc = -1;
    endtask

    // Key and direction are only correct on the final byte, so sampling at the 16th accept is exercised.
    task automatic send_block(input logic [127:0] blk, input logic ende, input bit gaps,
                              output int starts_before_last, output bit ok);
        int idx = 0;
        int guard = 0;
        ok = 1'b1;
        starts_before_last = n_start;
        while (idx < 16) begin
            @(negedge clk);
            if (guard > 400) begin ok = 1'b0; break; end
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                hif.in_valid = 1'b0;
            end else begin
                hif.in_valid = 1'b1;
                hif.in_data  = blk[127 - 8*idx -: 8];
            end
            hif.en_de = (idx == 15) ? ende : ~ende;
            hif.key   = (idx == 15) ? 128'h0 : {4{$urandom}};
            if (idx == 15) starts_before_last = n_start;
            if (hif.in_valid && hif.in_ready) idx++;
        end
        @(negedge clk);
        hif.in_valid = 1'b0;
        hif.key      = {4{$urandom}};
    endtask

    task automatic recv_block(input int mode, output logic [127:0] res, output int hs,
                              output int unstable, output logic ov_after, output bit ok);
        logic [7:0] prev_d = '0;
        bit prev_hold = 1'b0;
        int guard = 0;
        int k = 0;
        res = '0; hs = 0; unstable = 0; ok = 1'b1;
        while (hs < 16) begin
            @(negedge clk);
            if (guard > 500) begin ok = 1'b0; break; end
            guard++;
            if (prev_hold && hif.out_data !== prev_d) unstable++;
            hif.out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            k++;
            prev_hold = hif.out_valid && !hif.out_ready;
            prev_d    = hif.out_data;
            if (hif.out_valid && hif.out_ready) begin
                res = {res[119:0], hif.out_data};
                hs++;
            end
        end
        @(negedge clk);
        ov_after = hif.out_valid;
        hif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", hif.out_valid); end
        checks++; if (hif.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", hif.err); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b want 0", core_start); end
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL reset_core_reset got %b want 0", core_reset); end
        checks++; if (core_block !== 128'h0) begin errors++; $display("FAIL reset_core_block got %h want 0", core_block); end
        checks++; if (core_key !== 128'h0) begin errors++; $display("FAIL reset_core_key got %h want 0", core_key); end
        checks++; if (core_en_de !== 1'b0) begin errors++; $display("FAIL reset_core_en_de got %b want 0", core_en_de); end
        rst_n = 1'b1;
        #1;
        checks++; if (hif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", hif.in_ready); end
    endtask

    task automatic test_encrypt();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2;
        clear_mon();
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        recv_block(0, res, hs, unst, ova, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL enc_timeout got %b%b want 11", ok1, ok2); end
        checks++; if (res !== CT) begin errors++; $display("FAIL enc_result got %h want %h", res, CT); end
        checks++; if (hs !== 16) begin errors++; $display("FAIL enc_handshakes got %0d want 16", hs); end
        checks++; if (ova !== 1'b0) begin errors++; $display("FAIL enc_valid_drop got %b want 0", ova); end
        checks++; if (n_rst !== 1 || n_start !== 1) begin errors++; $display("FAIL enc_pulses got rst=%0d start=%0d want 1/1", n_rst, n_start); end
        checks++; if (last_start_cyc !== last_rst_cyc + 1) begin errors++; $display("FAIL enc_order got start@%0d rst@%0d want start=rst+1", last_start_cyc, last_rst_cyc); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL enc_err got %0d want 0", n_err); end
        checks++; if (core_en_de !== ENC || core_key !== 128'h0) begin errors++; $display("FAIL enc_operands got ende=%b key=%h want 0/0", core_en_de, core_key); end
    endtask

    task automatic test_decrypt();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2;
        clear_mon();
        send_block(CT, DEC, 1'b0, sb, ok1);
        recv_block(0, res, hs, unst, ova, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL dec_timeout got %b%b want 11", ok1, ok2); end
        checks++; if (res !== 128'h0) begin errors++; $display("FAIL dec_result got %h want 0", res); end
        checks++; if (core_en_de !== DEC) begin errors++; $display("FAIL dec_en_de got %b want 1", core_en_de); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL dec_err got %0d want 0", n_err); end
    endtask

    task automatic test_backpressure();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2;
        clear_mon();
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        recv_block(1, res, hs, unst, ova, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL bp_timeout got %b%b want 11", ok1, ok2); end
        checks++; if (res !== CT) begin errors++; $display("FAIL bp_result got %h want %h", res, CT); end
        checks++; if (unst !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unst); end
        checks++; if (hs !== 16 || ova !== 1'b0) begin errors++; $display("FAIL bp_handshakes got %0d valid_after=%b want 16/0", hs, ova); end
    endtask

    task automatic test_fast_core();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2;
        clear_mon();
        core_mode = 2;
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        recv_block(0, res, hs, unst, ova, ok2);
        core_mode = 0;
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL fast_timeout got %b%b want 11", ok1, ok2); end
        checks++; if (res !== CT) begin errors++; $display("FAIL fast_result got %h want %h", res, CT); end
        checks++; if (first_ov_cyc - last_start_cyc !== 6) begin errors++; $display("FAIL fast_latency got %0d want 6", first_ov_cyc - last_start_cyc); end
    endtask

    task automatic test_timeout();
        int sb; bit ok1; int guard;
        clear_mon();
        core_mode = 1;
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        guard = 0;
        while (n_err == 0 && guard < 100) begin @(negedge clk); guard++; end
        checks++; if (n_err !== 1) begin errors++; $display("FAIL tmo_err_count got %0d want 1", n_err); end
        checks++; if (last_err_cyc - last_start_cyc !== 17) begin errors++; $display("FAIL tmo_err_time got %0d want 17", last_err_cyc - last_start_cyc); end
        checks++; if (last_rst_cyc !== last_err_cyc || n_rst !== 2) begin errors++; $display("FAIL tmo_core_reset got rst@%0d n=%0d want @%0d n=2", last_rst_cyc, n_rst, last_err_cyc); end
        @(negedge clk);
        checks++; if (hif.in_ready !== 1'b1) begin errors++; $display("FAIL tmo_in_ready got %b want 1", hif.in_ready); end
        repeat (10) @(negedge clk);
        checks++; if (n_ov !== 0 || n_err !== 1) begin errors++; $display("FAIL tmo_quiet got ov=%0d err=%0d want 0/1", n_ov, n_err); end
        core_mode = 0;
    endtask

    task automatic test_async_reset();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2; int guard;
        clear_mon();
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        guard = 0;
        while (core_busy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        checks++; if (core_busy !== 1'b1) begin errors++; $display("FAIL ar_reach_run got %b want 1", core_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hif.out_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL ar_immediate got ov=%b start=%b want 0/0", hif.out_valid, core_start); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (hif.in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got %b want 1", hif.in_ready); end
        send_block(128'h0, ENC, 1'b0, sb, ok1);
        recv_block(0, res, hs, unst, ova, ok2);
        checks++; if (res !== CT || !(ok1 && ok2)) begin errors++; $display("FAIL ar_result got %h want %h", res, CT); end
    endtask

    task automatic test_input_gaps();
        logic [127:0] res; int hs, unst, sb; logic ova; bit ok1, ok2;
        clear_mon();
        send_block(128'h0, ENC, 1'b1, sb, ok1);
        checks++; if (sb !== 0) begin errors++; $display("FAIL gaps_early_start got %0d want 0", sb); end
        recv_block(0, res, hs, unst, ova, ok2);
        checks++; if (res !== CT || !(ok1 && ok2)) begin errors++; $display("FAIL gaps_result got %h want %h", res, CT); end
        checks++; if (n_start !== 1) begin errors++; $display("FAIL gaps_starts got %0d want 1", n_start); end
    endtask

    initial begin
        hif.in_data   = '0;
        hif.in_valid  = 1'b0;
        hif.en_de     = 1'b0;
        hif.key       = '0;
        hif.out_ready = 1'b0;
        clear_mon();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_fast_core();
        test_timeout();
        test_async_reset();
        test_input_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
